seq_multiple_checker: RTL and testbench

//   Multi-cycle, parametrised restoring divider that computes the quotient, the

---
 rtl/seq_multiple_checker.sv | 143 ++++++++++++++
 tb/tb_seq_multiple_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiple_checker.sv
// Restoring divider, one dividend bit per clock: quotient, remainder and a
// divisibility flag for an unsigned dividend and a run-time divisor.
module seq_multiple_checker #(
  parameter int WIDTH     = 36,
  parameter int DIV_WIDTH = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     n,
  input  logic [DIV_WIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 is_multiple,
  output logic                 div_by_zero
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0]     r_dvd;
  logic [WIDTH-1:0]     r_q;
  logic [DIV_WIDTH-1:0] r_div;
  logic [DIV_WIDTH:0]   r_pr;
  logic [IDX_W-1:0]     r_idx;

  logic                 r_done;
  logic [WIDTH-1:0]     r_quotient;
  logic [DIV_WIDTH-1:0] r_remainder;
  logic                 r_is_multiple;
  logic                 r_div_by_zero;

  logic                 w_accept;
  logic                 w_busy;
  logic [DIV_WIDTH:0]   w_pr_shift;
  logic [DIV_WIDTH:0]   w_pr_sub;
  logic [DIV_WIDTH:0]   w_pr_nxt;
  logic                 w_q_bit;
  logic [DIV_WIDTH-1:0] w_n_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          // A zero divisor skips the iteration entirely.
          w_state_nxt = (divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        w_busy = 1'b1;
        if (r_idx == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Partial remainder stays below the divisor, so its top bit is only
  // needed for the one cycle after the shift.
  always_comb begin
    w_pr_shift = {r_pr[DIV_WIDTH-1:0], r_dvd[WIDTH-1]};
    w_q_bit    = (w_pr_shift >= {1'b0, r_div});
    w_pr_sub   = w_pr_shift - {1'b0, r_div};
    w_pr_nxt   = w_q_bit ? w_pr_sub : w_pr_shift;
    w_n_low    = DIV_WIDTH'(r_dvd);
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dvd <= n;
      r_div <= divisor;
      r_pr  <= '0;
      r_q   <= '0;
      r_idx <= IDX_W'(WIDTH - 1);
    end else if (r_state == S_RUN) begin
      r_dvd <= r_dvd << 1;
      r_pr  <= w_pr_nxt;
      r_q   <= (r_q << 1) | WIDTH'(w_q_bit);
      r_idx <= r_idx - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_is_multiple <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_done <= 1'b1;
      if (r_div == '0) begin
        r_quotient    <= '1;
        r_remainder   <= w_n_low;
        r_is_multiple <= 1'b0;
        r_div_by_zero <= 1'b1;
      end else begin
        r_quotient    <= r_q;
        r_remainder   <= r_pr[DIV_WIDTH-1:0];
        r_is_multiple <= (r_pr == '0);
        r_div_by_zero <= 1'b0;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign busy        = w_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign is_multiple = r_is_multiple;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_seq_multiple_checker.sv
// Directed table plus multi-cycle corner sequences and a short random sweep
// for seq_multiple_checker.
module tb_seq_multiple_checker;

  localparam int W  = 36;
  localparam int DW = 25;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  n;
  logic [DW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [W-1:0]  quotient;
  logic [DW-1:0] remainder;
  logic          is_multiple;
  logic          div_by_zero;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_multiple_checker #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .n          (n),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .is_multiple(is_multiple),
    .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [W-1:0]  n;
    logic [DW-1:0] d;
    logic [W-1:0]  q;
    logic [DW-1:0] r;
    logic          m;
    logic          z;
    int            lat;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that shows done
  // (or after a 100-edge timeout, reported as a wrong latency).
  task automatic run_op(input logic [W-1:0] nv, input logic [DW-1:0] dv,
                        output int lat, output int busy_bad);
    logic exp_busy;
    n       = nv;
    divisor = dv;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    n        = ~nv;
    divisor  = dv ^ 25'h0AA_5555;
    busy_bad = 0;
    lat      = 0;
    if (busy !== (dv != '0)) busy_bad++;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      exp_busy = (dv != '0) && (lat <= W - 1);
      if (busy !== exp_busy) busy_bad++;
      if (done === 1'b1) break;
    end
  endtask

  initial begin
    int            lat;
    int            bb;
    int            dcount;
    int            bcount;
    logic [W-1:0]  gq;
    logic [DW-1:0] gr;
    logic [W-1:0]  rn;
    logic [DW-1:0] rd;
    logic [W-1:0]  eq;
    logic [DW-1:0] er;
    logic          em;
    logic          ez;

    rst_n   = 1'b0;
    start   = 1'b0;
    n       = '0;
    divisor = '0;

    tbl[0]  = '{36'd40_000_000,    25'd20_000_000, 36'd2,           25'd0,          1'b1, 1'b0, 37};
    tbl[1]  = '{36'd20_000_001,    25'd20_000_000, 36'd1,           25'd1,          1'b0, 1'b0, 37};
    tbl[2]  = '{36'd0,             25'd20_000_000, 36'd0,           25'd0,          1'b1, 1'b0, 37};
    tbl[3]  = '{36'hF_FFFF_FFFF,   25'd1,          36'hF_FFFF_FFFF, 25'd0,          1'b1, 1'b0, 37};
    tbl[4]  = '{36'hF_FFFF_FFFF,   25'h1FF_FFFF,   36'h800,         25'h7FF,        1'b0, 1'b0, 37};
    tbl[5]  = '{36'd5,             25'd0,          36'hF_FFFF_FFFF, 25'd5,          1'b0, 1'b1, 1};
    tbl[6]  = '{36'd60_000_000,    25'd20_000_000, 36'd3,           25'd0,          1'b1, 1'b0, 37};
    tbl[7]  = '{36'd123_456_789,   25'd1000,       36'd123_456,     25'd789,        1'b0, 1'b0, 37};
    tbl[8]  = '{36'd19_999_999,    25'd20_000_000, 36'd0,           25'd19_999_999, 1'b0, 1'b0, 37};
    tbl[9]  = '{36'hA_BCDE_F012,   25'd0,          36'hF_FFFF_FFFF, 25'h0DE_F012,   1'b0, 1'b1, 1};
    tbl[10] = '{36'd100,           25'd7,          36'd14,          25'd2,          1'b0, 1'b0, 37};
    tbl[11] = '{36'd1_000_000_000, 25'd20_000_000, 36'd50,          25'd0,          1'b1, 1'b0, 37};

    repeat (3) @(posedge clk);
    #1;
    check("reset_quotient", 64'(quotient), 64'd0);
    check("reset_flags", 64'({busy, done, remainder, is_multiple, div_by_zero}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].n, tbl[i].d, lat, bb);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
      check($sformatf("v%0d_quotient", i), 64'(quotient), 64'(tbl[i].q));
      check($sformatf("v%0d_remainder", i), 64'(remainder), 64'(tbl[i].r));
      check($sformatf("v%0d_mult_dz", i), 64'({is_multiple, div_by_zero}), 64'({tbl[i].m, tbl[i].z}));
      check($sformatf("v%0d_busy_bad", i), 64'(bb), 64'd0);
    end

    for (int k = 0; k < 150; k++) begin
      rn = W'({$urandom(), $urandom()});
      if (k % 3 == 0) rn = rn >> $urandom_range(0, W - 1);
      rd = DW'($urandom());
      if (k % 4 == 0) rd = rd >> $urandom_range(0, DW - 1);
      if (k % 25 == 0) rd = '0;
      if (rd == '0) begin
        eq = '1;
        er = DW'(rn);
        em = 1'b0;
        ez = 1'b1;
      end else begin
        eq = rn / W'(rd);
        er = DW'(rn % W'(rd));
        em = (er == '0);
        ez = 1'b0;
      end
      run_op(rn, rd, lat, bb);
      check($sformatf("rand%0d_result", k), {1'b0, quotient, remainder, is_multiple, div_by_zero},
            {1'b0, eq, er, em, ez});
      check($sformatf("rand%0d_latency", k), 64'(lat), (rd == '0) ? 64'd1 : 64'd37);
    end

    // Start during RUN must be ignored and produce no second done.
    n       = 36'd40_000_000;
    divisor = 25'd20_000_000;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n       = 36'd60_000_000;
    divisor = 25'd7;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    dcount = 0;
    gq     = '0;
    gr     = '1;
    repeat (60) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        dcount++;
        if (dcount == 1) begin
          gq = quotient;
          gr = remainder;
        end
      end
    end
    check("ignored_start_done_count", 64'(dcount), 64'd1);
    check("ignored_start_quotient", 64'(gq), 64'd2);
    check("ignored_start_remainder", 64'(gr), 64'd0);

    // Asynchronous reset in the middle of RUN.
    n       = 36'd123_456_789;
    divisor = 25'd1000;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_quotient", 64'(quotient), 64'd0);
    check("midrun_reset_flags", 64'({busy, done, remainder, is_multiple, div_by_zero}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    dcount = 0;
    bcount = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dcount++;
      if (busy === 1'b1) bcount++;
    end
    check("after_reset_no_done", 64'(dcount), 64'd0);
    check("after_reset_no_busy", 64'(bcount), 64'd0);

    run_op(36'd60_000_000, 25'd20_000_000, lat, bb);
    check("post_reset_latency", 64'(lat), 64'd37);
    check("post_reset_quotient", 64'(quotient), 64'd3);
    check("post_reset_remainder", 64'(remainder), 64'd0);
    check("post_reset_mult_dz", 64'({is_multiple, div_by_zero}), 64'b10);

    // Results hold after the done pulse.
    repeat (5) @(posedge clk);
    #1;
    check("hold_done_low", 64'(done), 64'd0);
    check("hold_quotient", 64'(quotient), 64'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
